// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the polyphonic MIDI tracker: channel-message status
// nibbles, the UART receiver state encoding and the per-status message length.
// -----------------------------------------------------------------------------
package midi_pkg;

   // Channel-voice status nibbles (upper four bits of the status byte)
   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CC       = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CH_AT    = 4'hD;
   localparam logic [3:0] PITCH    = 4'hE;

   // Serial receiver states
   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } rx_state_e;

   // Number of data bytes that follow a channel status byte
   function automatic logic [1:0] msg_len(input logic [3:0] nib);
      logic [1:0] len;
      case (nib)
         PROG, CH_AT: len = 2'd1;
         default:     len = 2'd2;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// -----------------------------------------------------------------------------
// midi_uart_rx
// Two-flop synchroniser plus 8N1 receive state machine for the MIDI line.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   midi_in    : raw asynchronous serial line, idle high
//   byte_valid : one-cycle pulse, a correctly framed byte is on rx_byte
//   rx_byte    : last framed byte, held until the next one
//   frame_err  : one-cycle pulse, stop bit was read as 0 (byte discarded)
// -----------------------------------------------------------------------------
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int CLK_PER_BIT = 128
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       midi_in,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int            CW      = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);

   logic            sync1_q;
   logic            rxb_q;
   rx_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            byte_valid_q, byte_valid_d;
   logic [7:0]      rx_byte_q, rx_byte_d;
   logic            frame_err_q, frame_err_d;

   // State, synchroniser and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q      <= 1'b1;
         rxb_q        <= 1'b1;
         state_q      <= RX_IDLE;
         cnt_q        <= '0;
         bit_q        <= 3'd0;
         shift_q      <= 8'h00;
         byte_valid_q <= 1'b0;
         rx_byte_q    <= 8'h00;
         frame_err_q  <= 1'b0;
      end else begin
         sync1_q      <= midi_in;
         rxb_q        <= sync1_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         rx_byte_q    <= rx_byte_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Next-state logic: start bit is re-checked at its midpoint, then every
   // later bit is sampled one full bit period apart, i.e. mid-bit.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      rx_byte_d    = rx_byte_q;
      frame_err_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!rxb_q) begin
               state_d = RX_START;
               cnt_d   = '0;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (!rxb_q) begin
                  state_d = RX_DATA;
                  bit_d   = 3'd0;
               end else begin
                  state_d = RX_IDLE;   // line went high again: glitch
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {rxb_q, shift_q[7:1]};   // LSB arrives first
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  state_d = RX_DATA;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rxb_q) begin
                  byte_valid_d = 1'b1;
                  rx_byte_d    = shift_q;
                  state_d      = RX_IDLE;
               end else begin
                  frame_err_d  = 1'b1;
                  state_d      = RX_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RX_WAIT_HIGH: begin
            if (rxb_q) begin
               state_d = RX_IDLE;
            end else begin
               state_d = RX_WAIT_HIGH;
            end
         end
         default: begin
            state_d = RX_IDLE;
         end
      endcase
   end

   assign byte_valid = byte_valid_q;
   assign rx_byte    = rx_byte_q;
   assign frame_err  = frame_err_q;

endmodule

// File: rtl/midi_poly_tracker.sv
// -----------------------------------------------------------------------------
// midi_poly_tracker
// MIDI input front end: serial receiver, channel-message parser with running
// status, and a VOICES-entry table of currently held notes.
//   clk          : system clock
//   rst_n        : synchronous active-low reset
//   midi_in      : raw asynchronous MIDI line, idle high
//   ch_sel       : channel to accept, sampled on each channel status byte
//   voice_active : bit i set while voice i holds a note
//   voice_note   : note of voice i at [7i+6:7i], meaningful while active
//   LED_out      : {any voice active, last accepted note-on number}
//   byte_valid   : one-cycle pulse per framed byte
//   rx_byte      : last framed byte
//   frame_err    : one-cycle pulse on a bad stop bit
//   overflow     : one-cycle pulse when a note-on found no free voice
// -----------------------------------------------------------------------------
module midi_poly_tracker
   import midi_pkg::*;
#(
   parameter int CLK_PER_BIT = 128,
   parameter int VOICES      = 4,
   parameter bit OMNI        = 1'b0
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  midi_in,
   input  logic [3:0]            ch_sel,
   output logic [VOICES-1:0]     voice_active,
   output logic [7*VOICES-1:0]   voice_note,
   output logic [7:0]            LED_out,
   output logic                  byte_valid,
   output logic [7:0]            rx_byte,
   output logic                  frame_err,
   output logic                  overflow
);

   logic                byte_valid_s;
   logic [7:0]          rx_byte_s;

   // Parser state
   logic                rs_valid_q, rs_valid_d;
   logic [3:0]          rs_nib_q, rs_nib_d;
   logic                chm_q, chm_d;
   logic                dcnt_q, dcnt_d;
   logic [6:0]          note_q, note_d;

   // Decoded note event for this cycle
   logic                ev_valid_s;
   logic                ev_on_s;
   logic [6:0]          ev_note_s;

   // Voice table
   logic [VOICES-1:0]   act_q, act_d;
   logic [7*VOICES-1:0] notes_q, notes_d;
   logic [6:0]          last_q, last_d;
   logic                ovf_q, ovf_d;
   logic [VOICES-1:0]   hit_s;
   logic [VOICES-1:0]   free_oh_s;

   midi_uart_rx #(
      .CLK_PER_BIT (CLK_PER_BIT)
   ) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .midi_in    (midi_in),
      .byte_valid (byte_valid_s),
      .rx_byte    (rx_byte_s),
      .frame_err  (frame_err)
   );

   // Parser and voice table registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rs_valid_q <= 1'b0;
         rs_nib_q   <= 4'h0;
         chm_q      <= 1'b0;
         dcnt_q     <= 1'b0;
         note_q     <= 7'h00;
         act_q      <= '0;
         notes_q    <= '0;
         last_q     <= 7'h00;
         ovf_q      <= 1'b0;
      end else begin
         rs_valid_q <= rs_valid_d;
         rs_nib_q   <= rs_nib_d;
         chm_q      <= chm_d;
         dcnt_q     <= dcnt_d;
         note_q     <= note_d;
         act_q      <= act_d;
         notes_q    <= notes_d;
         last_q     <= last_d;
         ovf_q      <= ovf_d;
      end
   end

   // Byte parser: running status, channel match and note event decode
   always_comb begin
      rs_valid_d = rs_valid_q;
      rs_nib_d   = rs_nib_q;
      chm_d      = chm_q;
      dcnt_d     = dcnt_q;
      note_d     = note_q;
      ev_valid_s = 1'b0;
      ev_on_s    = 1'b0;
      ev_note_s  = note_q;
      if (byte_valid_s) begin
         if (rx_byte_s[7]) begin
            if (rx_byte_s[7:4] != 4'hF) begin
               rs_valid_d = 1'b1;
               rs_nib_d   = rx_byte_s[7:4];
               dcnt_d     = 1'b0;
               chm_d      = OMNI || (rx_byte_s[3:0] == ch_sel);
            end else if (!rx_byte_s[3]) begin
               rs_valid_d = 1'b0;      // system common / exclusive
               dcnt_d     = 1'b0;
            end else begin
               rs_valid_d = rs_valid_q; // realtime leaves parser untouched
            end
         end else if (rs_valid_q) begin
            if (!dcnt_q) begin
               note_d = rx_byte_s[6:0];
            end else begin
               note_d = note_q;
            end
            if (dcnt_q || (msg_len(rs_nib_q) == 2'd1)) begin
               dcnt_d     = 1'b0;
               ev_valid_s = chm_q && ((rs_nib_q == NOTE_OFF) || (rs_nib_q == NOTE_ON));
               ev_on_s    = (rs_nib_q == NOTE_ON) && (rx_byte_s[6:0] != 7'h00);
               ev_note_s  = note_q;
            end else begin
               dcnt_d = 1'b1;
            end
         end else begin
            dcnt_d = dcnt_q;            // data with no running status
         end
      end else begin
         dcnt_d = dcnt_q;
      end
   end

   // Voice table update; free_oh_s isolates the lowest clear bit of act_q
   always_comb begin
      act_d     = act_q;
      notes_d   = notes_q;
      last_d    = last_q;
      ovf_d     = 1'b0;
      free_oh_s = ~act_q & (act_q + VOICES'(1));
      for (int i = 0; i < VOICES; i++) begin
         hit_s[i] = act_q[i] && (notes_q[7*i +: 7] == ev_note_s);
      end
      if (ev_valid_s) begin
         if (ev_on_s) begin
            if (|hit_s) begin
               act_d = act_q;           // already held
            end else if (|free_oh_s) begin
               act_d  = act_q | free_oh_s;
               last_d = ev_note_s;
               for (int i = 0; i < VOICES; i++) begin
                  if (free_oh_s[i]) begin
                     notes_d[7*i +: 7] = ev_note_s;
                  end else begin
                     notes_d[7*i +: 7] = notes_q[7*i +: 7];
                  end
               end
            end else begin
               ovf_d = 1'b1;
            end
         end else begin
            act_d = act_q & ~hit_s;
         end
      end else begin
         act_d = act_q;
      end
   end

   assign voice_active = act_q;
   assign voice_note   = notes_q;
   assign LED_out      = {|act_q, last_q};
   assign byte_valid   = byte_valid_s;
   assign rx_byte      = rx_byte_s;
   assign overflow     = ovf_q;

endmodule
